skintone_pixel_pipe: RTL and testbench

//  Parametrised successor to skintone_datapath. Classifies LANES RGB pixels per beat as skin/non-skin.

---
 rtl/skintone_pixel_pipe.sv | 93 +++++++++
 tb/tb_skintone_pixel_pipe.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/skintone_pixel_pipe.sv
// skintone_pixel_pipe: elastic multi-lane RGB skin-tone classifier, STAGES deep.
// Defining SKINTONE_STATS_EN adds saturating stat_beats/stat_skin output counters.
module skintone_pixel_pipe #(
  parameter int LANES    = 1,
  parameter int CH_W     = 8,
  parameter int RESULT_W = 8,
  parameter int STAGES   = 3,
  parameter int R_MIN    = 95,
  parameter int G_MIN    = 40,
  parameter int B_MIN    = 20,
  parameter int DIFF_MIN = 15
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [LANES*3*CH_W-1:0]    pixel_datain,
  input  logic                       pixel_datain_valid,
  output logic                       pixel_datain_ready,
  output logic [LANES*RESULT_W-1:0]  result_dataout,
  output logic                       result_dataout_valid,
  input  logic                       result_dataout_ready
`ifdef SKINTONE_STATS_EN
  ,
  output logic [31:0]                stat_beats,
  output logic [31:0]                stat_skin
`endif
);
  localparam int DW = LANES*RESULT_W;
  logic [STAGES-1:0]  v_q, v_d, en;
  logic [LANES*5-1:0] cmp_q, cmp_d;
  logic [DW-1:0]      res_q [1:STAGES-1];
  logic [DW-1:0]      res_d [1:STAGES-1];
  // R-G is taken one bit wider and signed so that R<G is negative instead of wrapping.
  function automatic logic [4:0] cmp(input logic [3*CH_W-1:0] p);
    logic [CH_W-1:0] r, g, b;
    r = p[3*CH_W-1:2*CH_W];
    g = p[2*CH_W-1:CH_W];
    b = p[CH_W-1:0];
    return {r > CH_W'(R_MIN), g > CH_W'(G_MIN), b > CH_W'(B_MIN), r > b,
            ($signed({1'b0, r}) - $signed({1'b0, g})) > $signed((CH_W+1)'(DIFF_MIN))};
  endfunction
  always_comb begin
    cmp_d = cmp_q;
    res_d = res_q;
    // A stage may load unless it and every stage after it are full while the sink stalls.
    for (int k = 0; k < STAGES; k++)
      en[k] = result_dataout_ready || ((v_q >> k) != ({STAGES{1'b1}} >> k));
    v_d[0] = en[0] ? pixel_datain_valid : v_q[0];
    for (int k = 1; k < STAGES; k++) v_d[k] = en[k] ? v_q[k-1] : v_q[k];
    for (int l = 0; l < LANES; l++) begin
      cmp_d[l*5 +: 5] = en[0] ? cmp(pixel_datain[l*3*CH_W +: 3*CH_W]) : cmp_q[l*5 +: 5];
      res_d[1][l*RESULT_W +: RESULT_W] = en[1] ? {RESULT_W{&cmp_q[l*5 +: 5]}}
                                               : res_q[1][l*RESULT_W +: RESULT_W];
    end
    for (int k = 2; k < STAGES; k++) res_d[k] = en[k] ? res_q[k-1] : res_q[k];
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v_q   <= '0;
      cmp_q <= '0;
      for (int k = 1; k < STAGES; k++) res_q[k] <= '0;
    end else begin
      v_q   <= v_d;
      cmp_q <= cmp_d;
      res_q <= res_d;
    end
  end
  assign pixel_datain_ready   = en[0];
  assign result_dataout       = res_q[STAGES-1];
  assign result_dataout_valid = v_q[STAGES-1];
`ifdef SKINTONE_STATS_EN
  logic        fire;
  logic [31:0] beats_q, beats_d, skin_q, skin_d;
  logic [32:0] skin_sum;
  always_comb begin
    fire = v_q[STAGES-1] && result_dataout_ready;
    skin_sum = {1'b0, skin_q};
    for (int l = 0; l < LANES; l++) skin_sum = skin_sum + 33'(res_q[STAGES-1][l*RESULT_W]);
    beats_d = (fire && beats_q != '1) ? beats_q + 32'd1 : beats_q;
    skin_d  = !fire ? skin_q : skin_sum[32] ? '1 : skin_sum[31:0];
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      beats_q <= '0;
      skin_q  <= '0;
    end else begin
      beats_q <= beats_d;
      skin_q  <= skin_d;
    end
  end
  assign stat_beats = beats_q;
  assign stat_skin  = skin_q;
`endif
endmodule

// File: tb/tb_skintone_pixel_pipe.sv
// tb_skintone_pixel_pipe: scoreboard bench for the single-lane and dual-lane pipe.
module tb_skintone_pixel_pipe;
  localparam int S = 3;
  logic clk = 0, rst = 0;
  always #5 clk = ~clk;
  logic [23:0] px = '0;
  logic        iv = 0, ir, ov, ordy = 1;
  logic [7:0]  res;
  logic [47:0] px2 = '0;
  logic        iv2 = 0, ir2, ov2;
  logic [15:0] res2;
`ifdef SKINTONE_STATS_EN
  logic [31:0] sb, ss, sb2, ss2;
`endif
  int checks = 0, errors = 0, acc = 0;
  logic [7:0]  cur_exp = '0;
  logic [15:0] cur_exp2 = '0;
  logic [7:0]  q[$];
  logic [15:0] q2[$];
  logic [23:0] pt[4];
  logic [7:0]  et[4];
  logic        done = 0;

  skintone_pixel_pipe #(.LANES(1), .STAGES(S)) dut (
    .clk(clk), .rst(rst), .pixel_datain(px), .pixel_datain_valid(iv), .pixel_datain_ready(ir),
    .result_dataout(res), .result_dataout_valid(ov), .result_dataout_ready(ordy)
`ifdef SKINTONE_STATS_EN
    , .stat_beats(sb), .stat_skin(ss)
`endif
  );
  skintone_pixel_pipe #(.LANES(2), .STAGES(S)) dut2 (
    .clk(clk), .rst(rst), .pixel_datain(px2), .pixel_datain_valid(iv2), .pixel_datain_ready(ir2),
    .result_dataout(res2), .result_dataout_valid(ov2), .result_dataout_ready(1'b1)
`ifdef SKINTONE_STATS_EN
    , .stat_beats(sb2), .stat_skin(ss2)
`endif
  );

  function automatic logic [23:0] pix(input int r, input int g, input int b);
    return {8'(r), 8'(g), 8'(b)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got timeout expected completion", name);
  endtask

  // Expected values enter the scoreboard on acceptance; outputs are popped on handshake.
  always @(negedge clk) begin
    if (rst && iv && ir) begin q.push_back(cur_exp); acc++; end
    if (rst && iv2 && ir2) q2.push_back(cur_exp2);
    if (ov && ordy) begin
      if (q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_beat: got %0h expected none", res);
      end else chk("result", res, q.pop_front());
    end
    if (ov2) begin
      if (q2.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_beat2: got %0h expected none", res2);
      end else chk("result2", res2, q2.pop_front());
    end
  end

  task automatic send(input logic [23:0] p, input logic [7:0] e);
    int n = 0;
    px = p; cur_exp = e; iv = 1;
    @(negedge clk);
    while (!ir && n < 200) begin @(negedge clk); n++; end
    if (!ir) begin timeout("accept"); iv = 0; end
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int n = 0;
    while ((q.size() != 0 || q2.size() != 0) && n < 200) begin @(negedge clk); n++; end
    chk("drain", q.size() + q2.size(), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    pt[0] = pix(200, 100, 80); et[0] = 8'hFF;
    pt[1] = pix(90, 50, 30);   et[1] = 8'h00;
    pt[2] = pix(96, 41, 21);   et[2] = 8'hFF;
    pt[3] = pix(100, 85, 21);  et[3] = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_valid", ov, 0);
    chk("reset_data", res, 0);
    chk("reset_valid2", ov2, 0);
`ifdef SKINTONE_STATS_EN
    chk("reset_stat_beats", sb, 0);
    chk("reset_stat_skin", ss, 0);
`endif
    rst = 1;
    @(posedge clk); #1;
    chk("ready_after_reset", ir, 1);
    send(pix(200, 100, 80), 8'hFF);
    iv = 0;
    repeat (S - 2) begin @(posedge clk); #1; chk("latency_early", ov, 0); end
    @(posedge clk); #1;
    chk("latency_valid", ov, 1);
    drain();
    send(pix(90, 50, 30), 8'h00);
    send(pix(150, 160, 40), 8'h00);
    send(pix(96, 41, 21), 8'hFF);
    send(pix(95, 41, 21), 8'h00);
    send(pix(100, 85, 21), 8'h00);
    iv = 0;
    drain();
    begin
      int a0, n;
      a0 = acc; ordy = 0; done = 0; n = 0;
      fork
        begin
          for (int i = 0; i < 20; i++) send(pt[i % 4], et[i % 4]);
          iv = 0;
          done = 1;
        end
      join_none
      repeat (10) @(posedge clk);
      #1;
      chk("stall_accepted", acc - a0, S);
      chk("stall_ready", ir, 0);
      chk("stall_valid", ov, 1);
      ordy = 1;
      while (!done && n < 500) begin @(posedge clk); n++; end
      if (!done) timeout("stream");
      drain();
      chk("stream_accepted", acc - a0, 20);
    end
    begin
      int n = 0;
      px2 = {pix(200, 100, 80), pix(10, 10, 10)}; cur_exp2 = 16'hFF00; iv2 = 1;
      @(negedge clk);
      while (!ir2 && n < 50) begin @(negedge clk); n++; end
      if (!ir2) timeout("accept2");
      @(posedge clk); #1;
      iv2 = 0;
      drain();
    end
    ordy = 0;
    send(pt[0], et[0]);
    send(pt[1], et[1]);
    send(pt[2], et[2]);
    iv = 0;
    @(posedge clk); #1;
    chk("inflight_valid", ov, 1);
    #3;
    rst = 0;
    #1;
    chk("async_reset_valid", ov, 0);
    chk("async_reset_data", res, 0);
    q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1;
    ordy = 1;
    repeat (10) @(posedge clk);
    #1;
    chk("no_stale_valid", ov, 0);
`ifdef SKINTONE_STATS_EN
    chk("stats_cleared", sb, 0);
    send(pix(200, 100, 80), 8'hFF);
    iv = 0;
    px2 = {pix(200, 100, 80), pix(10, 10, 10)}; cur_exp2 = 16'hFF00; iv2 = 1;
    @(posedge clk); #1;
    iv2 = 0;
    drain();
    chk("stat_beats", sb, 1);
    chk("stat_skin", ss, 1);
    chk("stat_beats2", sb2, 1);
    chk("stat_skin2", ss2, 1);
    chk("stat_beats_total", sb + sb2, 2);
    chk("stat_skin_total", ss + ss2, 2);
`endif
    send(pix(96, 41, 21), 8'hFF);
    iv = 0;
    drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
